encoder8to3_pending: RTL and testbench

- Sequential 8-to-3 event encoder; the inverse direction of the team's 3-to-8 decoder.
- Each input bit is an event request. Events are latched into a pending set and issued one at a time as a 3-bit binary code on a valid/ready handshake.
- Sits between event/interrupt sources and a consumer that accepts one index per cycle.

---
 rtl/enc_pkg.sv | 22 ++
 rtl/encoder8to3_pending_prio_pick8.sv | 40 ++++
 rtl/encoder8to3_pending.sv | 102 ++++++++++
 tb/tb_encoder8to3_pending.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc_pkg
//  Description : Shared constants and helpers for the 8-to-3 pending event
//                encoder and its priority picker.
//  Contents    : ENC_N  - number of event lines
//                ENC_W  - width of a binary event index
//                onehot8 - index to one-hot mask conversion
//  Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int ENC_N = 8;
    localparam int ENC_W = 3;

    // One-hot mask for a 3-bit index.
    function automatic logic [ENC_N-1:0] onehot8(input logic [ENC_W-1:0] idx);
        onehot8 = {{(ENC_N-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/encoder8to3_pending_prio_pick8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_pick8
//  Description : Combinational rotating-priority picker over 8 requests.
//                Searches start, start+1, ... wrapping 7->0 and returns the
//                first set request. start=0 gives plain lowest-index priority.
//  Ports       : req   [7:0] in  - request vector
//                start [2:0] in  - index searched first
//                idx   [2:0] out - chosen index (0 when nothing requested)
//                any         out - at least one request set
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_pick8
    import enc_pkg::*;
(
    input  logic [ENC_N-1:0] req,
    input  logic [ENC_W-1:0] start,
    output logic [ENC_W-1:0] idx,
    output logic             any
);

    logic [ENC_W-1:0] cand;

    // Walk the search order backwards so the last hit written is the one
    // closest to start; the 3-bit sum wraps naturally from 7 to 0.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = ENC_N - 1; k >= 0; k--) begin
            cand = start + ENC_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule : prio_pick8
`default_nettype wire

// File: rtl/encoder8to3_pending.sv
`default_nettype none
// ============================================================================
//  Module      : encoder8to3_pending
//  Description : Sequential 8-to-3 event encoder. Event pulses are latched
//                into a pending set and issued one at a time as a binary
//                index on a valid/ready handshake.
//  Parameters  : ROUND_ROBIN - 0: lowest pending index wins
//                              1: search starts after the last issued index
//  Ports       : clk            in  - clock, rising edge
//                rst            in  - synchronous active-high reset
//                in       [7:0] in  - event pulses, multi-hot allowed
//                out      [2:0] out - issued event index (registered)
//                valid          out - out holds an issued event (registered)
//                ready          in  - consumer accepts out this cycle
//                pending  [7:0] out - latched events not yet issued
//                overflow       out - pulse: event merged into a pending bit
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder8to3_pending
    import enc_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ENC_N-1:0] in,
    output logic [ENC_W-1:0] out,
    output logic             valid,
    input  logic             ready,
    output logic [ENC_N-1:0] pending,
    output logic             overflow
);

    logic [ENC_N-1:0] pending_q, pending_d;
    logic [ENC_W-1:0] out_q,     out_d;
    logic             valid_q,   valid_d;
    logic             overflow_q, overflow_d;
    logic [ENC_W-1:0] rr_ptr_q,  rr_ptr_d;

    logic [ENC_W-1:0] pick_start;
    logic [ENC_W-1:0] sel;
    logic             sel_any;
    logic             fire;
    logic             load;
    logic [ENC_N-1:0] load_mask;

    // Selection only looks at the registered pending set, so an event
    // arriving this cycle can never bypass the pending stage.
    assign pick_start = ROUND_ROBIN ? rr_ptr_q : '0;

    prio_pick8 u_pick (
        .req   (pending_q),
        .start (pick_start),
        .idx   (sel),
        .any   (sel_any)
    );

    assign fire      = valid_q & ready;
    // The output slot is free when empty or being drained this cycle.
    assign load      = (~valid_q | fire) & sel_any;
    assign load_mask = load ? onehot8(sel) : '0;

    always_comb begin
        pending_d  = (pending_q & ~load_mask) | in;
        // A bit being loaded this cycle is not a collision: the new pulse
        // simply re-pends it as a fresh event.
        overflow_d = |(in & pending_q & ~load_mask);
        out_d      = out_q;
        valid_d    = valid_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            out_d    = sel;
            valid_d  = 1'b1;
            rr_ptr_d = sel + ENC_W'(1);
        end else if (fire) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign pending  = pending_q;
    assign out      = out_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule : encoder8to3_pending
`default_nettype wire

// File: tb/tb_encoder8to3_pending.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder8to3_pending
//  Description : Self-checking bench for encoder8to3_pending. Runs a fixed
//                priority instance and a round-robin instance side by side on
//                the same stimulus and compares both against a behavioural
//                model of the pending set and output slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder8to3_pending;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_s = 8'h00;
    logic       ready_s = 1'b0;

    logic [2:0] out0, out1;
    logic       valid0, valid1;
    logic [7:0] pend0, pend1;
    logic       ovf0, ovf1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, index 0 = fixed priority, 1 = round robin.
    logic [7:0] m_pend  [2];
    int         m_out   [2];
    logic       m_valid [2];
    logic       m_ovf   [2];
    int         m_ptr   [2];

    always #5 clk = ~clk;

    encoder8to3_pending #(.ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .rst(rst), .in(in_s), .out(out0), .valid(valid0),
        .ready(ready_s), .pending(pend0), .overflow(ovf0)
    );

    encoder8to3_pending #(.ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst(rst), .in(in_s), .out(out1), .valid(valid1),
        .ready(ready_s), .pending(pend1), .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance the model by one clock edge using the rules of the encoder:
    // drain/load the output slot, then merge the new pulses.
    task automatic model_step(input logic [7:0] vin, input logic vrdy, input logic vrst);
        for (int d = 0; d < 2; d++) begin
            if (vrst) begin
                m_pend[d] = 8'h00; m_out[d] = 0; m_valid[d] = 1'b0;
                m_ovf[d] = 1'b0;   m_ptr[d] = 0;
            end else begin
                bit   fire, ld;
                int   start, sel;
                logic [7:0] mask;
                fire  = m_valid[d] && vrdy;
                ld    = (!m_valid[d] || fire) && (m_pend[d] != 8'h00);
                mask  = 8'h00;
                sel   = -1;
                if (ld) begin
                    start = (d == 1) ? m_ptr[d] : 0;
                    for (int k = 0; k < 8; k++)
                        if (sel < 0 && m_pend[d][(start + k) % 8]) sel = (start + k) % 8;
                    mask = 8'(1 << sel);
                end
                m_ovf[d]  = ((vin & m_pend[d] & ~mask) != 8'h00);
                m_pend[d] = (m_pend[d] & ~mask) | vin;
                if (ld) begin
                    m_out[d] = sel; m_valid[d] = 1'b1; m_ptr[d] = (sel + 1) % 8;
                end else if (fire) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
    endtask

    task automatic cmp_model();
        chk("fix_out",   {5'b0, out0},   8'(m_out[0]));
        chk("fix_valid", {7'b0, valid0}, {7'b0, m_valid[0]});
        chk("fix_pend",  pend0,          m_pend[0]);
        chk("fix_ovf",   {7'b0, ovf0},   {7'b0, m_ovf[0]});
        chk("rr_out",    {5'b0, out1},   8'(m_out[1]));
        chk("rr_valid",  {7'b0, valid1}, {7'b0, m_valid[1]});
        chk("rr_pend",   pend1,          m_pend[1]);
        chk("rr_ovf",    {7'b0, ovf1},   {7'b0, m_ovf[1]});
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic cycle(input logic [7:0] vin, input logic vrdy, input logic vrst);
        @(negedge clk);
        in_s = vin; ready_s = vrdy; rst = vrst;
        model_step(vin, vrdy, vrst);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 8'h00; m_out[d] = 0; m_valid[d] = 1'b0;
            m_ovf[d] = 1'b0;   m_ptr[d] = 0;
        end

        // Reset with all inputs active: in is ignored on the reset edge.
        cycle(8'hFF, 1'b0, 1'b1);
        chk("rst_pend",  pend0, 8'h00);
        chk("rst_valid", {7'b0, valid0}, 8'h00);
        chk("rst_out",   {5'b0, out0}, 8'h00);
        chk("rst_ovf",   {7'b0, ovf1}, 8'h00);

        // Single event on bit 5.
        cycle(8'h20, 1'b1, 1'b0);
        chk("single_pend", pend0, 8'h20);
        chk("single_v0",   {7'b0, valid0}, 8'h00);
        cycle(8'h00, 1'b1, 1'b0);
        chk("single_valid", {7'b0, valid0}, 8'h01);
        chk("single_out",   {5'b0, out0}, 8'd5);
        chk("single_empty", pend0, 8'h00);
        cycle(8'h00, 1'b1, 1'b0);
        chk("single_done", {7'b0, valid0}, 8'h00);

        // Fixed-priority burst: expect 0, 2, 7 back to back.
        cycle(8'h85, 1'b1, 1'b0);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_0", {5'b0, out0}, 8'd0);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_2", {5'b0, out0}, 8'd2);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_7", {5'b0, out0}, 8'd7);
        chk("burst_v", {7'b0, valid0}, 8'h01);
        cycle(8'h00, 1'b1, 1'b0);
        chk("burst_end", {7'b0, valid0}, 8'h00);

        // Backpressure and overflow on bit 0.
        cycle(8'h01, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        chk("bp_out",  {5'b0, out0}, 8'd0);
        chk("bp_valid", {7'b0, valid0}, 8'h01);
        cycle(8'h01, 1'b0, 1'b0);
        chk("bp_repend", pend0, 8'h01);
        chk("bp_noovf",  {7'b0, ovf0}, 8'h00);
        cycle(8'h01, 1'b0, 1'b0);
        chk("bp_ovf", {7'b0, ovf0}, 8'h01);
        cycle(8'h00, 1'b0, 1'b0);
        chk("bp_ovf_pulse", {7'b0, ovf0}, 8'h00);
        chk("bp_hold", {7'b0, valid0}, 8'h01);
        cycle(8'h00, 1'b1, 1'b0);
        chk("bp_second", {5'b0, out0}, 8'd0);
        chk("bp_second_v", {7'b0, valid0}, 8'h01);
        cycle(8'h00, 1'b1, 1'b0);
        chk("bp_drain", {7'b0, valid0}, 8'h00);

        // Round-robin wrap from a fresh pointer with all lines held high.
        cycle(8'h00, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            cycle(8'hFF, 1'b1, 1'b0);
            if (k >= 2) begin
                chk("rr_wrap_out", {5'b0, out1}, 8'((k - 2) % 8));
                chk("rr_wrap_ovf", {7'b0, ovf1}, 8'h01);
                chk("fix_hold0",   {5'b0, out0}, 8'd0);
            end
        end
        for (int k = 0; k < 10; k++) cycle(8'h00, 1'b1, 1'b0);
        chk("rr_drained", {7'b0, valid1}, 8'h00);

        // Reset in the middle of a stalled transfer.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h02, 1'b0, 1'b0);
        cycle(8'h3C, 1'b0, 1'b0);
        chk("mid_pend",  pend0, 8'h3C);
        chk("mid_out",   {5'b0, out0}, 8'd1);
        chk("mid_valid", {7'b0, valid0}, 8'h01);
        cycle(8'h00, 1'b0, 1'b1);
        chk("mid_rst_pend",  pend1, 8'h00);
        chk("mid_rst_valid", {7'b0, valid1}, 8'h00);
        chk("mid_rst_out",   {5'b0, out1}, 8'h00);
        cycle(8'h00, 1'b0, 1'b0);
        chk("mid_after", {7'b0, valid0}, 8'h00);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] r_in;
            r_in = 8'($urandom) & 8'($urandom);
            cycle(r_in, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 60) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_encoder8to3_pending
`default_nettype wire
